// File: rtl/fixed_pkg.sv
// Shared types and constants for the sequential fixed-point multiplier.
// Holds the controller state encoding and the rounding-mode encodings.
package fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic ROUND_FLOOR   = 1'b0;
  localparam logic ROUND_HALF_UP = 1'b1;

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational finish stage: signs the magnitude product, rounds, rescales
// by FRAC and either saturates or wraps into WIDTH bits.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 11
) (
  input  logic [2*WIDTH-1:0] mag,
  input  logic               sign,
  input  logic               round_mode,
  input  logic               sat_en,
  output logic [WIDTH-1:0]   p,
  output logic               ovf
);

  localparam int XW = 2*WIDTH + 1;
  localparam logic [XW-1:0] RND = XW'(1) << (FRAC-1);
  localparam logic signed [XW-1:0] MAX_V = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = ~MAX_V;

  logic signed [XW-1:0] signed_prod;
  logic signed [XW-1:0] rounded;
  logic signed [XW-1:0] shifted;

  // Extra headroom bit keeps the most-negative squared product positive.
  assign signed_prod = sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  assign rounded     = signed_prod + $signed((round_mode == ROUND_HALF_UP) ? RND : '0);
  assign shifted     = rounded >>> FRAC;
  assign ovf         = (shifted > MAX_V) || (shifted < MIN_V);

  always_comb begin
    p = shifted[WIDTH-1:0];
    if (ovf && sat_en) begin
      p = shifted[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fixed_mul_seq.sv
// Sequential signed fixed-point multiplier: magnitude shift-add over WIDTH
// cycles, then a single finish cycle for sign, rounding and saturation.
module fixed_mul_seq
  import fixed_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             round_mode,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             out_ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_mag_reg, a_mag_next;
  logic [WIDTH-1:0]   b_mag_reg, b_mag_next;
  logic               sign_reg, sign_next;
  logic               round_reg, round_next;
  logic               sat_reg, sat_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [WIDTH-1:0]   p_reg, p_next;
  logic               ovf_reg, ovf_next;

  logic [2*WIDTH-1:0] partial;
  logic [WIDTH-1:0]   fin_p;
  logic               fin_ovf;

  // Held low during reset so nothing is offered while the block is cleared.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign out_p     = p_reg;
  assign out_ovf   = ovf_reg;

  assign partial = b_mag_reg[cnt_reg] ? ({{WIDTH{1'b0}}, a_mag_reg} << cnt_reg) : '0;

  fixed_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_round_sat (
    .mag        (acc_reg),
    .sign       (sign_reg),
    .round_mode (round_reg),
    .sat_en     (sat_reg),
    .p          (fin_p),
    .ovf        (fin_ovf)
  );

  always_comb begin
    state_next = state_reg;
    a_mag_next = a_mag_reg;
    b_mag_next = b_mag_reg;
    sign_next  = sign_reg;
    round_next = round_reg;
    sat_next   = sat_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    p_next     = p_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          // Unsigned negation maps the most-negative operand to 2^(WIDTH-1).
          a_mag_next = in_a[WIDTH-1] ? -in_a : in_a;
          b_mag_next = in_b[WIDTH-1] ? -in_b : in_b;
          sign_next  = in_a[WIDTH-1] ^ in_b[WIDTH-1];
          round_next = round_mode;
          sat_next   = sat_en;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = MUL;
        end
      end
      MUL: begin
        acc_next = acc_reg + partial;
        if (cnt_reg == CW'(WIDTH-1)) begin
          state_next = FIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FIN: begin
        p_next     = fin_p;
        ovf_next   = fin_ovf;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_mag_reg <= '0;
      b_mag_reg <= '0;
      sign_reg  <= 1'b0;
      round_reg <= ROUND_FLOOR;
      sat_reg   <= 1'b0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      p_reg     <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_mag_reg <= a_mag_next;
      b_mag_reg <= b_mag_next;
      sign_reg  <= sign_next;
      round_reg <= round_next;
      sat_reg   <= sat_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      p_reg     <= p_next;
      ovf_reg   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Directed and randomized bench for fixed_mul_seq (WIDTH=16, FRAC=11) with
// a queue of expected products filled at accept and drained at output.
module tb_fixed_mul_seq;

  localparam int WIDTH = 16;
  localparam int FRAC  = 11;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             round_mode = 1'b0;
  logic             sat_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_p;
  logic             out_ovf;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  fixed_mul_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .round_mode (round_mode),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product computed with full-width integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic rm, input logic sat);
    exp_t   e;
    longint prod;
    longint s;
    prod = longint'($signed(a)) * longint'($signed(b));
    if (rm) prod = prod + (longint'(1) << (FRAC-1));
    s = prod >>> FRAC;
    e.ovf = (s > 32767) || (s < -32768);
    if (e.ovf && sat) e.p = (s < 0) ? 16'h8000 : 16'h7FFF;
    else              e.p = s[WIDTH-1:0];
    return e;
  endfunction

  // Returns in the first period after the accept edge; inputs are then scrambled.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic rm, input logic sat, input exp_t e);
    int guard;
    guard = 0;
    in_a = a; in_b = b; round_mode = rm; sat_en = sat; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(e);
    $display("[TB] accept a=%h b=%h rm=%0d sat=%0d exp_p=%h exp_ovf=%0d", a, b, rm, sat, e.p, e.ovf);
    #1;
    in_valid = 1'b0;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    round_mode = 1'($urandom); sat_en = 1'($urandom);
  endtask

  // Waits for out_valid, optionally holds, then checks and consumes the result.
  task automatic recv(input string tag, input int hold, input bit rnd_ready, output int lat);
    exp_t             e;
    logic [WIDTH-1:0] held_p;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (rnd_ready) out_ready = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    out_ready = 1'b0;
    chk({tag, "_valid_wait"}, {31'd0, out_valid}, 32'd1);
    held_p = out_p;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_p"}, {16'd0, out_p}, {16'd0, held_p});
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_p"}, {16'd0, out_p}, {16'd0, e.p});
      chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, e.ovf});
    end
    $display("[TB] result %s p=%h ovf=%0d latency=%0d", tag, out_p, out_ovf, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] p, input logic ovf);
    exp_t e;
    e.p = p; e.ovf = ovf;
    return e;
  endfunction

  initial begin
    int lat;
    logic [WIDTH-1:0] ra, rb;
    logic rrm, rsat;

    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_p", {16'd0, out_p}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic products and latency.
    send(16'h0C00, 16'h1000, 1'b0, 1'b1, mk(16'h1800, 1'b0));
    recv("pos", 0, 1'b0, lat);
    chk("latency", lat, 32'd18);
    send(16'hF400, 16'h1000, 1'b0, 1'b1, mk(16'hE800, 1'b0));
    recv("neg", 0, 1'b0, lat);

    // Overflow handling.
    send(16'h4000, 16'h2000, 1'b0, 1'b1, mk(16'h7FFF, 1'b1));
    recv("ovf_sat", 0, 1'b0, lat);
    send(16'h4000, 16'h2000, 1'b0, 1'b0, mk(16'h0000, 1'b1));
    recv("ovf_wrap", 0, 1'b0, lat);
    send(16'h8000, 16'h8000, 1'b0, 1'b1, mk(16'h7FFF, 1'b1));
    recv("minsq_sat", 0, 1'b0, lat);

    // Rounding at the LSB boundary.
    send(16'h0001, 16'h0400, 1'b0, 1'b1, mk(16'h0000, 1'b0));
    recv("rnd_floor_pos", 0, 1'b0, lat);
    send(16'h0001, 16'h0400, 1'b1, 1'b1, mk(16'h0001, 1'b0));
    recv("rnd_half_pos", 0, 1'b0, lat);
    send(16'hFFFF, 16'h0400, 1'b0, 1'b1, mk(16'hFFFF, 1'b0));
    recv("rnd_floor_neg", 0, 1'b0, lat);
    send(16'hFFFF, 16'h0400, 1'b1, 1'b1, mk(16'h0000, 1'b0));
    recv("rnd_half_neg", 0, 1'b0, lat);
    send(16'h0000, 16'h8123, 1'b0, 1'b1, mk(16'h0000, 1'b0));
    recv("zero_neg", 0, 1'b0, lat);

    // Backpressure in DONE.
    send(16'h0C00, 16'hF000, 1'b1, 1'b0, mk(16'hE800, 1'b0));
    recv("hold", 5, 1'b0, lat);

    // Back-to-back with random gaps against the reference model.
    for (int t = 0; t < 24; t++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      if (t % 6 == 0) ra = 16'h8000;
      if (t % 7 == 3) rb = 16'h0000;
      if (t % 5 == 1) rb = WIDTH'($urandom_range(0, 16'h0FFF));
      rrm = 1'($urandom); rsat = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(ra, rb, rrm, rsat, model(ra, rb, rrm, rsat));
      recv("rand", 0, 1'b1, lat);
    end

    // Reset in the middle of the shift-add phase.
    send(16'h1234, 16'h5678, 1'b0, 1'b1, mk(16'h0000, 1'b0));
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_p", {16'd0, out_p}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'h0800, 16'h0800, 1'b0, 1'b1, mk(16'h0800, 1'b0));
    recv("after_rst", 0, 1'b0, lat);
    chk("after_rst_latency", lat, 32'd18);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
